multicycle_control_fsm: RTL and testbench

Main control state machine for the multicycle ARM datapath: decodes the instruction fields held in the instruction register and sequences fetch, decode, execute, memory and write-back cycles. It produces the unconditioned write/branch requests (RegW, MemW, FlagW, PCS) consumed by the condition-gating logic, plus all datapath mux selects and ALU control. It sits between the instruction register and the conditional-execution stage of the processor controller.

---
 rtl/multicycle_control_fsm_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm_alu_decoder.sv | 40 ++++
 rtl/multicycle_control_fsm.sv | 122 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
package multicycle_control_fsm_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned RD_W     = 4;
    localparam int unsigned CMD_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Op field encodings (Op=11 is treated as a NOP)
    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;

    // Data-processing cmd encodings
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

    localparam logic [RD_W-1:0] RD_PC = 4'hF;

    // Registered control word driven onto the datapath
    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] flag_w;
        logic       reg_w;
        logic       mem_w;
        logic       pcs;
    } ctrl_t;

    // Control word for the FETCH state, also the reset value
    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c            = '0;
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction fields in, datapath control requests out.
interface multicycle_control_fsm_if;
    import multicycle_control_fsm_pkg::*;

    logic [OP_W-1:0]    Op;
    logic [FUNCT_W-1:0] Funct;
    logic [RD_W-1:0]    Rd;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic [1:0]         ResultSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUControl;
    logic [1:0]         FlagW;
    logic               RegW;
    logic               MemW;
    logic               PCS;
    logic [STATE_W-1:0] State;

    // Instruction-register side: supplies fields, observes controls
    modport master (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, FlagW, RegW, MemW, PCS, State
    );

    // Controller side
    modport slave (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, FlagW, RegW, MemW, PCS, State
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU operation and flag-write decode from the data-processing Funct field.
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic               ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               NoWrite
);

    logic [CMD_W-1:0] cmd;
    logic             unused_imm;

    assign cmd        = Funct[4:1];
    assign unused_imm = Funct[5];

    // NoWrite depends only on the held cmd so ALUWB can use it with ALUOp low
    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        NoWrite    = (cmd == CMD_CMP);
        if (ALUOp) begin
            case (cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: ALUControl = ALU_SUB;
                default: ALUControl = ALU_ADD;
            endcase
            if (cmd == CMD_CMP) begin
                FlagW = 2'b11;
            end else begin
                FlagW = {Funct[0], Funct[0] & ~ALUControl[1]};
            end
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM main controller: state sequencing and registered Moore controls.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.slave  bus
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic       alu_op_d;
    logic       branch_d;
    logic       no_write;
    logic [1:0] alu_control_d;
    logic [1:0] flag_w_d;

    // ALU decode evaluated for the state about to be entered
    assign alu_op_d = (next_state == EXECR) || (next_state == EXECI);

    multicycle_control_fsm_alu_decoder u_alu_decoder (
        .ALUOp      (alu_op_d),
        .Funct      (bus.Funct),
        .ALUControl (alu_control_d),
        .FlagW      (flag_w_d),
        .NoWrite    (no_write)
    );

    // Next-state sequencing
    always_comb begin
        next_state = state;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = bus.Funct[5] ? EXECI : EXECR;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            MEMWB:  next_state = FETCH;
            MEMWR:  next_state = FETCH;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Control word for next_state, registered alongside the state
    always_comb begin
        ctrl_d   = '0;
        branch_d = 1'b0;
        case (next_state)
            FETCH: ctrl_d = fetch_ctrl();
            DECODE: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = SRCB_FOUR;
                ctrl_d.result_src = RES_ALURESULT;
            end
            MEMADR: ctrl_d.alu_src_b = SRCB_IMM;
            MEMRD:  ctrl_d.adr_src   = 1'b1;
            MEMWB: begin
                ctrl_d.result_src = RES_DATA;
                ctrl_d.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl_d.adr_src = 1'b1;
                ctrl_d.mem_w   = 1'b1;
            end
            EXECR: begin
                ctrl_d.alu_src_b   = SRCB_REG;
                ctrl_d.alu_control = alu_control_d;
                ctrl_d.flag_w      = flag_w_d;
            end
            EXECI: begin
                ctrl_d.alu_src_b   = SRCB_IMM;
                ctrl_d.alu_control = alu_control_d;
                ctrl_d.flag_w      = flag_w_d;
            end
            ALUWB: ctrl_d.reg_w = ~no_write;
            BRANCH: begin
                ctrl_d.alu_src_b  = SRCB_IMM;
                ctrl_d.result_src = RES_ALURESULT;
                branch_d          = 1'b1;
            end
            default: ctrl_d = fetch_ctrl();
        endcase
        ctrl_d.pcs = branch_d | (ctrl_d.reg_w & (bus.Rd == RD_PC));
    end

    // State and control registers; reset forces FETCH immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            ctrl_q <= fetch_ctrl();
        end else begin
            state  <= next_state;
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.IRWrite    = ctrl_q.ir_write;
    assign bus.NextPC     = ctrl_q.next_pc;
    assign bus.AdrSrc     = ctrl_q.adr_src;
    assign bus.ResultSrc  = ctrl_q.result_src;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.ALUControl = ctrl_q.alu_control;
    assign bus.FlagW      = ctrl_q.flag_w;
    assign bus.RegW       = ctrl_q.reg_w;
    assign bus.MemW       = ctrl_q.mem_w;
    assign bus.PCS        = ctrl_q.pcs;
    assign bus.State      = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle ARM main controller.
module tb_multicycle_control_fsm;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        bus.Op    = op;
        bus.Funct = funct;
        bus.Rd    = rd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        load(2'b11, 6'b000000, 4'h0);

        // Reset state
        #12;
        chk("rst_state", 8'(bus.State), 8'd0);
        chk("rst_irwrite", 8'(bus.IRWrite), 8'd1);
        chk("rst_nextpc", 8'(bus.NextPC), 8'd1);
        chk("rst_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("rst_srcb", 8'(bus.ALUSrcB), 8'd2);
        chk("rst_ressrc", 8'(bus.ResultSrc), 8'd2);
        chk("rst_regw", 8'(bus.RegW), 8'd0);
        chk("rst_pcs", 8'(bus.PCS), 8'd0);
        step();
        rst = 1'b1;

        // LDR r3
        load(2'b01, 6'b011001, 4'h3);
        chk("ldr_s0", 8'(bus.State), 8'd0);
        step(); chk("ldr_s1", 8'(bus.State), 8'd1);
        chk("ldr_dec_regw", 8'(bus.RegW), 8'd0);
        step(); chk("ldr_s2", 8'(bus.State), 8'd2);
        chk("ldr_adr_srcb", 8'(bus.ALUSrcB), 8'd1);
        step(); chk("ldr_s3", 8'(bus.State), 8'd3);
        chk("ldr_rd_adrsrc", 8'(bus.AdrSrc), 8'd1);
        chk("ldr_rd_regw", 8'(bus.RegW), 8'd0);
        step(); chk("ldr_s4", 8'(bus.State), 8'd4);
        chk("ldr_wb_regw", 8'(bus.RegW), 8'd1);
        chk("ldr_wb_ressrc", 8'(bus.ResultSrc), 8'd1);
        chk("ldr_wb_pcs", 8'(bus.PCS), 8'd0);
        step(); chk("ldr_s5", 8'(bus.State), 8'd0);
        chk("ldr_fetch_regw", 8'(bus.RegW), 8'd0);

        // Reset pulse in the middle of MEMRD
        step(); step(); step();
        chk("mid_pre_state", 8'(bus.State), 8'd3);
        #1 rst = 1'b0;
        #1;
        chk("mid_state", 8'(bus.State), 8'd0);
        chk("mid_irwrite", 8'(bus.IRWrite), 8'd1);
        chk("mid_nextpc", 8'(bus.NextPC), 8'd1);
        chk("mid_regw", 8'(bus.RegW), 8'd0);
        chk("mid_adrsrc", 8'(bus.AdrSrc), 8'd0);
        load(2'b11, 6'b000000, 4'h0);
        step();
        chk("mid_hold", 8'(bus.State), 8'd0);
        rst = 1'b1;
        step(); chk("mid_release", 8'(bus.State), 8'd1);
        step(); chk("mid_back", 8'(bus.State), 8'd0);

        // STR
        load(2'b01, 6'b011000, 4'h2);
        step(); chk("str_s1", 8'(bus.State), 8'd1);
        step(); chk("str_s2", 8'(bus.State), 8'd2);
        step(); chk("str_s3", 8'(bus.State), 8'd5);
        chk("str_memw", 8'(bus.MemW), 8'd1);
        chk("str_adrsrc", 8'(bus.AdrSrc), 8'd1);
        chk("str_regw", 8'(bus.RegW), 8'd0);
        step(); chk("str_s4", 8'(bus.State), 8'd0);
        chk("str_memw_off", 8'(bus.MemW), 8'd0);

        // ADDS register, Rd=2
        load(2'b00, 6'b001001, 4'h2);
        step(); chk("adds_s1", 8'(bus.State), 8'd1);
        step(); chk("adds_s2", 8'(bus.State), 8'd6);
        chk("adds_aluctl", 8'(bus.ALUControl), 8'd0);
        chk("adds_flagw", 8'(bus.FlagW), 8'd3);
        chk("adds_srcb", 8'(bus.ALUSrcB), 8'd0);
        step(); chk("adds_s3", 8'(bus.State), 8'd8);
        chk("adds_regw", 8'(bus.RegW), 8'd1);
        chk("adds_pcs", 8'(bus.PCS), 8'd0);
        chk("adds_wb_flagw", 8'(bus.FlagW), 8'd0);
        step(); chk("adds_s4", 8'(bus.State), 8'd0);

        // ADDS register, Rd=15
        load(2'b00, 6'b001001, 4'hF);
        step(); step(); chk("addpc_s2", 8'(bus.State), 8'd6);
        chk("addpc_exec_pcs", 8'(bus.PCS), 8'd0);
        step(); chk("addpc_s3", 8'(bus.State), 8'd8);
        chk("addpc_regw", 8'(bus.RegW), 8'd1);
        chk("addpc_pcs", 8'(bus.PCS), 8'd1);
        step(); chk("addpc_pcs_off", 8'(bus.PCS), 8'd0);

        // CMP immediate
        load(2'b00, 6'b110101, 4'h0);
        step(); step(); chk("cmp_s2", 8'(bus.State), 8'd7);
        chk("cmp_aluctl", 8'(bus.ALUControl), 8'd1);
        chk("cmp_flagw", 8'(bus.FlagW), 8'd3);
        chk("cmp_srcb", 8'(bus.ALUSrcB), 8'd1);
        step(); chk("cmp_s3", 8'(bus.State), 8'd8);
        chk("cmp_regw", 8'(bus.RegW), 8'd0);
        chk("cmp_pcs", 8'(bus.PCS), 8'd0);
        step();

        // ANDS register
        load(2'b00, 6'b000001, 4'h4);
        step(); step(); chk("ands_s2", 8'(bus.State), 8'd6);
        chk("ands_aluctl", 8'(bus.ALUControl), 8'd2);
        chk("ands_flagw", 8'(bus.FlagW), 8'd2);
        step(); chk("ands_regw", 8'(bus.RegW), 8'd1);
        step();

        // ORR immediate without S, then SUBS register
        load(2'b00, 6'b111000, 4'h5);
        step(); step(); chk("orr_s2", 8'(bus.State), 8'd7);
        chk("orr_aluctl", 8'(bus.ALUControl), 8'd3);
        chk("orr_flagw", 8'(bus.FlagW), 8'd0);
        step(); step();
        load(2'b00, 6'b000101, 4'h6);
        step(); step();
        chk("subs_aluctl", 8'(bus.ALUControl), 8'd1);
        chk("subs_flagw", 8'(bus.FlagW), 8'd3);
        step(); step();

        // Branch
        load(2'b10, 6'b100000, 4'h0);
        step(); chk("b_s1", 8'(bus.State), 8'd1);
        step(); chk("b_s2", 8'(bus.State), 8'd9);
        chk("b_pcs", 8'(bus.PCS), 8'd1);
        chk("b_srcb", 8'(bus.ALUSrcB), 8'd1);
        chk("b_ressrc", 8'(bus.ResultSrc), 8'd2);
        chk("b_regw", 8'(bus.RegW), 8'd0);
        step(); chk("b_s3", 8'(bus.State), 8'd0);
        chk("b_pcs_off", 8'(bus.PCS), 8'd0);

        // Op=11 behaves as a two-cycle NOP
        load(2'b11, 6'b001001, 4'hF);
        step(); chk("nop_s1", 8'(bus.State), 8'd1);
        chk("nop_writes", 8'({bus.RegW, bus.MemW, bus.PCS, bus.FlagW}), 8'd0);
        step(); chk("nop_s2", 8'(bus.State), 8'd0);
        chk("nop_writes2", 8'({bus.RegW, bus.MemW, bus.PCS, bus.FlagW}), 8'd0);
        chk("nop_irwrite", 8'(bus.IRWrite), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
